radiation_playback_scheduler: RTL

RADIATION_PLAYBACK_SCHEDULER -- requirements
Module: radiation_playback_scheduler

---
 rtl/radiation_playback_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/radiation_playback_scheduler.sv
// Radiation playback: fetches {delay, sample} words from memory, waits the per-sample
// delay, then offers the sample to the PS or to the histogram and requests refills.
module radiation_playback_scheduler #(
   parameter int ADDR_WIDTH  = 14,
   parameter int MEM_LATENCY = 2,
   parameter int HOLDOFF     = 50
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  useHardware,
   input  logic [31:0]           wrCount,
   input  logic [15:0]           loadFloor,
   output logic [ADDR_WIDTH-1:0] memAddr,
   input  logic [31:0]           memData,
   output logic                  psValid,
   output logic [15:0]           psValue,
   input  logic                  psAck,
   output logic                  hwValid,
   output logic [15:0]           hwValue,
   input  logic                  hwReady,
   output logic                  refillIrq,
   input  logic                  refillClear,
   output logic [31:0]           sentCount,
   output logic                  busy,
   output logic                  starved,
   output logic                  overrun
);
   localparam int                   FLAST_I  = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;
   localparam logic [7:0]           FLAST    = 8'(FLAST_I);
   localparam int                   HO_W     = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [HO_W-1:0]      HO_LOAD  = HO_W'(HOLDOFF);
   localparam logic [HO_W-1:0]      HO_ONE   = HO_W'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [32:0]          OUT_LIMIT = 33'd1 << ADDR_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DELAY, S_ISSUE, S_STARVED} state_t;

   state_t                r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_sent;
   logic [15:0]           r_sample;
   logic [15:0]           r_dcnt;
   logic [7:0]            r_fcnt;
   logic                  r_route;
   logic                  r_irq;
   logic [HO_W-1:0]       r_holdoff;
   logic                  r_starved;
   logic                  r_overrun;

   logic                  w_start_acc, w_hs, w_hs_ok, w_latch, w_busy;
   logic                  w_ps_valid, w_hw_valid, w_refill_set;
   logic [31:0]           w_out, w_sent_inc;

   assign w_start_acc = (r_state == S_IDLE) && start;
   assign w_out       = wrCount - r_sent;
   assign w_sent_inc  = r_sent + 32'd1;
   // stop aborts an in-flight handshake: nothing is counted on that edge
   assign w_hs_ok     = w_hs && !stop;
   assign w_refill_set = (r_holdoff == '0) &&
                         (w_start_acc || (w_busy && (wrCount != 32'd0) &&
                                          (w_out <= {16'd0, loadFloor})));

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_latch    = 1'b0;
      w_hs       = 1'b0;
      w_busy     = (r_state != S_IDLE);
      w_ps_valid = (r_state == S_ISSUE) && !r_route;
      w_hw_valid = (r_state == S_ISSUE) && r_route;
      case (r_state)
         S_IDLE:    if (start) w_next = (wrCount == 32'd0) ? S_STARVED : S_FETCH;
         S_FETCH: begin
            if (r_fcnt == FLAST) begin
               w_latch = 1'b1;
               w_next  = S_DELAY;
            end
         end
         S_DELAY:   if (r_dcnt == 16'd0) w_next = S_ISSUE;
         S_ISSUE: begin
            w_hs = r_route ? hwReady : psAck;
            if (w_hs) w_next = (wrCount != w_sent_inc) ? S_FETCH : S_STARVED;
         end
         S_STARVED: if (wrCount != r_sent) w_next = S_FETCH;
         default:   w_next = S_IDLE;
      endcase
      if (stop && !w_start_acc) w_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr    <= '0;
         r_sent    <= '0;
         r_sample  <= '0;
         r_dcnt    <= '0;
         r_fcnt    <= '0;
         r_route   <= 1'b0;
         r_irq     <= 1'b0;
         r_holdoff <= '0;
         r_starved <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_start_acc) begin
            r_addr    <= '0;
            r_sent    <= '0;
            r_starved <= 1'b0;
            r_overrun <= 1'b0;
         end else begin
            if (w_hs_ok) begin
               r_addr <= r_addr + ADDR_ONE;
               r_sent <= w_sent_inc;
               if (wrCount == w_sent_inc) r_starved <= 1'b1;
            end
            if (w_busy && ({1'b0, w_out} > OUT_LIMIT)) r_overrun <= 1'b1;
         end

         r_fcnt <= ((r_state == S_FETCH) && (w_next == S_FETCH)) ? r_fcnt + 8'd1 : 8'd0;

         if (w_latch) begin
            r_sample <= memData[15:0];
            r_dcnt   <= memData[31:16];
            r_route  <= useHardware;
         end else if ((r_state == S_DELAY) && (r_dcnt != 16'd0)) begin
            r_dcnt <= r_dcnt - 16'd1;
         end

         // clear beats a coincident set and re-arms the holdoff window
         if (refillClear) begin
            r_irq     <= 1'b0;
            r_holdoff <= HO_LOAD;
         end else begin
            if (r_holdoff != '0) r_holdoff <= r_holdoff - HO_ONE;
            if (w_refill_set)    r_irq     <= 1'b1;
         end
      end
   end

   assign memAddr   = r_addr;
   assign psValid   = w_ps_valid;
   assign hwValid   = w_hw_valid;
   assign psValue   = r_sample;
   assign hwValue   = r_sample;
   assign refillIrq = r_irq;
   assign sentCount = r_sent;
   assign busy      = w_busy;
   assign starved   = r_starved;
   assign overrun   = r_overrun;

endmodule
